sobel_window_ctrl: RTL and testbench

//  Sequencer for the two cascaded single-line FIFO buffers feeding the 3x3 Sobel window.

---
 rtl/sobel_window_ctrl_pkg.sv | 25 ++
 rtl/sobel_window_ctrl_if.sv | 37 +++
 rtl/sobel_window_ctrl_rc_counter.sv | 68 ++++++
 rtl/sobel_window_ctrl.sv | 133 +++++++++++++
 tb/tb_sobel_window_ctrl.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sobel_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_ctrl_pkg
// Description : Shared types and default geometry for the Sobel window
//               sequencer (FSM state encoding, image size defaults).
// Revision    : 1.0 - initial release
// ============================================================================
package sobel_window_ctrl_pkg;

  localparam int unsigned C_IMG_W_DEF = 512;
  localparam int unsigned C_IMG_H_DEF = 512;
  localparam int unsigned C_CW_DEF    = 10;
  localparam int unsigned C_RW_DEF    = 10;

  // Frame sequencer states, 3-bit explicit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FILL  = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage : sobel_window_ctrl_pkg
`default_nettype wire

// File: rtl/sobel_window_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_ctrl_if
// Description : Pixel-source / line-buffer side signals of the Sobel window
//               sequencer.
//   pix_valid_i  pixel present this cycle        (source  -> ctrl)
//   lb0_done_i   line buffer 0 holds a full line (buffer  -> ctrl)
//   lb1_done_i   line buffer 1 holds a full line (buffer  -> ctrl)
//   lb_rst_o     active-high reset of both line buffers
//   lb0_we_o     write enable, line buffer 0
//   lb1_we_o     write enable, line buffer 1
//   win_shift_o  shift the 3x3 window registers one column
//   master: the controller; slave: pixel source + buffers/window.
// Revision    : 1.0 - initial release
// ============================================================================
interface sobel_window_ctrl_if;

  logic pix_valid_i;
  logic lb0_done_i;
  logic lb1_done_i;
  logic lb_rst_o;
  logic lb0_we_o;
  logic lb1_we_o;
  logic win_shift_o;

  modport master (
    input  pix_valid_i, lb0_done_i, lb1_done_i,
    output lb_rst_o, lb0_we_o, lb1_we_o, win_shift_o
  );

  modport slave (
    output pix_valid_i, lb0_done_i, lb1_done_i,
    input  lb_rst_o, lb0_we_o, lb1_we_o, win_shift_o
  );

endinterface : sobel_window_ctrl_if
`default_nettype wire

// File: rtl/sobel_window_ctrl_rc_counter.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_ctrl_rc_counter
// Description : Next-pixel column/row position counter. Column wraps at
//               IMG_W-1 and bumps the row.
//   clk, rst    clock, synchronous active-low reset
//   clr_i       return position to (0,0)
//   inc_i       advance one pixel
//   col_o/row_o position the next accepted pixel will occupy
//   last_col_o  position is the last column of a line
//   last_pix_o  position is the last pixel of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_ctrl_rc_counter #(
  parameter int unsigned IMG_W = 512,
  parameter int unsigned IMG_H = 512,
  parameter int unsigned CW    = 10,
  parameter int unsigned RW    = 10
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          clr_i,
  input  wire logic          inc_i,
  output logic [CW-1:0]      col_o,
  output logic [RW-1:0]      row_o,
  output logic               last_col_o,
  output logic               last_pix_o
);

  localparam logic [CW-1:0] C_LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] C_LAST_ROW = RW'(IMG_H - 1);

  logic [CW-1:0] ncol_q, ncol_d;
  logic [RW-1:0] nrow_q, nrow_d;

  always_comb begin
    ncol_d = ncol_q;
    nrow_d = nrow_q;
    if (clr_i) begin
      ncol_d = '0;
      nrow_d = '0;
    end else if (inc_i) begin
      if (ncol_q == C_LAST_COL) begin
        ncol_d = '0;
        nrow_d = (nrow_q == C_LAST_ROW) ? '0 : nrow_q + RW'(1);
      end else begin
        ncol_d = ncol_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ncol_q <= '0;
      nrow_q <= '0;
    end else begin
      ncol_q <= ncol_d;
      nrow_q <= nrow_d;
    end
  end

  assign col_o      = ncol_q;
  assign row_o      = nrow_q;
  assign last_col_o = (ncol_q == C_LAST_COL);
  assign last_pix_o = (ncol_q == C_LAST_COL) && (nrow_q == C_LAST_ROW);

endmodule : sobel_window_ctrl_rc_counter
`default_nettype wire

// File: rtl/sobel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sobel_window_ctrl
// Description : Sequencer for the two cascaded line buffers feeding a 3x3
//               Sobel window. Gates buffer writes, tracks pixel position,
//               flags valid neighbourhoods and signals end of frame.
//   clk, rst      clock, synchronous active-low reset
//   start_i       begin a frame (honoured only when idle)
//   lb_if         pixel valid in, line-buffer done in, buffer reset/write
//                 enables and window shift out
//   win_valid_o   window centred on a full neighbourhood (registered)
//   col_o/row_o   position of the last accepted pixel
//   busy_o        frame in progress
//   frame_done_o  one-cycle end-of-frame pulse
//   err_o         sticky: buffers not full when a window was declared valid
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_window_ctrl
  import sobel_window_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W = C_IMG_W_DEF,
  parameter int unsigned IMG_H = C_IMG_H_DEF,
  parameter int unsigned CW    = C_CW_DEF,
  parameter int unsigned RW    = C_RW_DEF
) (
  input  wire logic                clk,
  input  wire logic                rst,
  input  wire logic                start_i,
  sobel_window_ctrl_if.master      lb_if,
  output logic                     win_valid_o,
  output logic [CW-1:0]            col_o,
  output logic [RW-1:0]            row_o,
  output logic                     busy_o,
  output logic                     frame_done_o,
  output logic                     err_o
);

  state_e        state_q, state_d;
  logic          win_valid_q, win_valid_d;
  logic          err_q, err_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  logic          accept;
  logic          in_clear;
  logic [CW-1:0] ncol;
  logic [RW-1:0] nrow;
  logic          last_col;
  logic          last_pix;
  logic          deep_row;

  assign in_clear = (state_q == ST_CLEAR);
  assign accept   = lb_if.pix_valid_i && ((state_q == ST_FILL) || (state_q == ST_RUN));
  // Rows 0/1 only prime the buffers; from row 2 both buffers must be full.
  assign deep_row = (nrow >= RW'(2));

  sobel_window_ctrl_rc_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .CW    (CW),
    .RW    (RW)
  ) u_rc_counter (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (in_clear),
    .inc_i      (accept),
    .col_o      (ncol),
    .row_o      (nrow),
    .last_col_o (last_col),
    .last_pix_o (last_pix)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FILL;
      ST_FILL: begin
        if (accept && last_pix)                           state_d = ST_DONE;
        else if (accept && last_col && (nrow == RW'(1)))  state_d = ST_RUN;
      end
      ST_RUN:   if (accept && last_pix) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    err_d       = err_q;
    win_valid_d = accept && deep_row && (ncol >= CW'(2));
    if (accept) begin
      col_d = ncol;
      row_d = nrow;
    end
    if (in_clear) begin
      err_d = 1'b0;
    end else if (accept && deep_row && !(lb_if.lb0_done_i && lb_if.lb1_done_i)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      err_q       <= err_d;
    end
  end

  assign lb_if.lb_rst_o    = !rst || in_clear;
  assign lb_if.lb0_we_o    = accept;
  assign lb_if.lb1_we_o    = accept && lb_if.lb0_done_i;
  assign lb_if.win_shift_o = accept;

  assign win_valid_o  = win_valid_q;
  assign col_o        = col_q;
  assign row_o        = row_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = (state_q == ST_DONE);
  assign err_o        = err_q;

endmodule : sobel_window_ctrl
`default_nettype wire

// File: tb/tb_sobel_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_window_ctrl
// Description : Self-checking bench for sobel_window_ctrl on an 8x4 image
//               with behavioural line-buffer fill models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_window_ctrl;

  localparam int W = 8;
  localparam int H = 4;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       win_valid;
  logic [2:0] col;
  logic [1:0] row;
  logic       busy;
  logic       frame_done;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  // Buffer fill model: a line buffer reports done once it has taken W writes
  // since its last reset.
  int  fill0 = 0;
  int  fill1 = 0;
  bit  kill_lb1 = 1'b0;

  sobel_window_ctrl_if u_if ();

  assign u_if.lb0_done_i = (fill0 >= W);
  assign u_if.lb1_done_i = (fill1 >= W) && !kill_lb1;

  always @(posedge clk) begin
    if (u_if.lb_rst_o) begin
      fill0 <= 0;
      fill1 <= 0;
    end else begin
      if (u_if.lb0_we_o && fill0 < W) fill0 <= fill0 + 1;
      if (u_if.lb1_we_o && fill1 < W) fill1 <= fill1 + 1;
    end
  end

  sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .CW(3), .RW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .lb_if        (u_if.master),
    .win_valid_o  (win_valid),
    .col_o        (col),
    .row_o        (row),
    .busy_o       (busy),
    .frame_done_o (frame_done),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  // Drives one frame. abort_at >= 0 asserts reset instead of pixel abort_at.
  // err_row2 withholds lb1 done during row 2. noise adds ignored start/pixel
  // activity around and inside the frame.
  task automatic run_frame(input int gap_pct, input int abort_at, input bit err_row2,
                           input bit noise, output int wv_cnt, output bit done_seen);
    int k;
    int cyc;
    bit v;
    bit exp_wv;
    bit exp_err;
    logic [2:0] ec;
    logic [1:0] er;
    k = 0; cyc = 0; wv_cnt = 0; done_seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    u_if.pix_valid_i = noise;
    #1;
    n_checks++;
    if (u_if.lb0_we_o !== 1'b0) begin
      n_errors++; $display("FAIL idle_pix_dropped: lb0_we=%b want 0", u_if.lb0_we_o);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    n_checks++;
    if (u_if.lb_rst_o !== 1'b1 || busy !== 1'b1 || u_if.lb0_we_o !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_cycle: lb_rst=%b busy=%b lb0_we=%b want 1 1 0",
               u_if.lb_rst_o, busy, u_if.lb0_we_o);
    end
    while (k < NPIX) begin
      @(negedge clk);
      if (k == abort_at) begin
        u_if.pix_valid_i = 1'b0;
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || u_if.lb_rst_o !== 1'b1 || frame_done !== 1'b0 ||
            err !== 1'b0 || win_valid !== 1'b0 || col !== 3'd0 || row !== 2'd0) begin
          n_errors++;
          $display("FAIL abort_reset: busy=%b lb_rst=%b done=%b err=%b wv=%b col=%0d row=%0d want 0 1 0 0 0 0 0",
                   busy, u_if.lb_rst_o, frame_done, err, win_valid, col, row);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          n_checks++;
          if (frame_done !== 1'b0 || busy !== 1'b0 || u_if.lb_rst_o !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_idle: done=%b busy=%b lb_rst=%b want 0 0 0",
                     frame_done, busy, u_if.lb_rst_o);
          end
        end
        return;
      end
      v = ($urandom_range(99) >= gap_pct);
      u_if.pix_valid_i = v;
      kill_lb1 = err_row2 && (k >= 2 * W) && (k < 3 * W);
      start = (noise && k > W) ? 1'($urandom_range(1)) : 1'b0;
      #1;
      n_checks++;
      if (u_if.lb0_we_o !== v || u_if.win_shift_o !== v || u_if.lb1_we_o !== (v && k >= W)) begin
        n_errors++;
        $display("FAIL we_gating k=%0d: lb0=%b shift=%b lb1=%b want %b %b %b",
                 k, u_if.lb0_we_o, u_if.win_shift_o, u_if.lb1_we_o, v, v, v && k >= W);
      end
      @(posedge clk); #1;
      if (v) begin
        ec = 3'(k % W);
        er = 2'(k / W);
        exp_wv = (k / W >= 2) && (k % W >= 2);
        exp_err = err_row2 && (k >= 2 * W);
        n_checks++;
        if (col !== ec || row !== er || win_valid !== exp_wv || err !== exp_err) begin
          n_errors++;
          $display("FAIL pixel k=%0d: col=%0d row=%0d wv=%b err=%b want %0d %0d %b %b",
                   k, col, row, win_valid, err, ec, er, exp_wv, exp_err);
        end
        if (win_valid === 1'b1) wv_cnt++;
        n_checks++;
        if (frame_done !== (k == NPIX - 1) || busy !== 1'b1) begin
          n_errors++;
          $display("FAIL frame_done k=%0d: done=%b busy=%b want %b 1",
                   k, frame_done, busy, k == NPIX - 1);
        end
        if (frame_done === 1'b1) done_seen = 1'b1;
        k++;
      end else begin
        n_checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
          n_errors++;
          $display("FAIL gap_cycle k=%0d: wv=%b done=%b want 0 0", k, win_valid, frame_done);
        end
      end
      cyc++;
      if (cyc > 2000) begin
        n_errors++;
        $display("FAIL frame_timeout: accepted=%0d want %0d", k, NPIX);
        return;
      end
    end
    // DONE cycle: pixels and start here must be ignored.
    @(negedge clk);
    start = noise;
    kill_lb1 = 1'b0;
    u_if.pix_valid_i = noise;
    #1;
    n_checks++;
    if (u_if.lb0_we_o !== 1'b0) begin
      n_errors++; $display("FAIL done_pix_dropped: lb0_we=%b want 0", u_if.lb0_we_o);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || col !== 3'd7 || row !== 2'd3 ||
        win_valid !== 1'b0 || err !== err_row2) begin
      n_errors++;
      $display("FAIL post_frame: busy=%b done=%b col=%0d row=%0d wv=%b err=%b want 0 0 7 3 0 %b",
               busy, frame_done, col, row, win_valid, err, err_row2);
    end
    @(negedge clk);
    start = 1'b0;
    u_if.pix_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    u_if.pix_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (u_if.lb_rst_o !== 1'b1 || busy !== 1'b0 || win_valid !== 1'b0 || col !== 3'd0 ||
        row !== 2'd0 || frame_done !== 1'b0 || err !== 1'b0 || u_if.lb0_we_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: lb_rst=%b busy=%b wv=%b col=%0d row=%0d done=%b err=%b we=%b want 1 0 0 0 0 0 0 0",
               u_if.lb_rst_o, busy, win_valid, col, row, frame_done, err, u_if.lb0_we_o);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || u_if.lb_rst_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: busy=%b lb_rst=%b want 0 0", busy, u_if.lb_rst_o);
    end
  endtask

  task automatic test_back_to_back();
    int wv; bit dn;
    run_frame(0, -1, 1'b0, 1'b0, wv, dn);
    n_checks++;
    if (wv !== 12 || dn !== 1'b1) begin
      n_errors++; $display("FAIL b2b_summary: wv=%0d done=%b want 12 1", wv, dn);
    end
  endtask

  task automatic test_random_gaps();
    int wv; bit dn;
    run_frame(50, -1, 1'b0, 1'b0, wv, dn);
    n_checks++;
    if (wv !== 12 || dn !== 1'b1) begin
      n_errors++; $display("FAIL gaps_summary: wv=%0d done=%b want 12 1", wv, dn);
    end
  endtask

  task automatic test_midframe_reset();
    int wv; bit dn;
    run_frame(0, 13, 1'b0, 1'b0, wv, dn);
    n_checks++;
    if (dn !== 1'b0) begin
      n_errors++; $display("FAIL abort_no_done: done=%b want 0", dn);
    end
    run_frame(30, -1, 1'b0, 1'b0, wv, dn);
    n_checks++;
    if (wv !== 12 || dn !== 1'b1) begin
      n_errors++; $display("FAIL after_abort_summary: wv=%0d done=%b want 12 1", wv, dn);
    end
  endtask

  task automatic test_err_row2();
    int wv; bit dn;
    run_frame(25, -1, 1'b1, 1'b0, wv, dn);
    // err must stay sticky through idle and clear only on the next frame.
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (err !== 1'b1) begin
      n_errors++; $display("FAIL err_sticky: err=%b want 1", err);
    end
    run_frame(0, -1, 1'b0, 1'b0, wv, dn);
    n_checks++;
    if (err !== 1'b0 || wv !== 12) begin
      n_errors++; $display("FAIL err_cleared: err=%b wv=%0d want 0 12", err, wv);
    end
  endtask

  task automatic test_ignored_inputs();
    int wv; bit dn;
    @(negedge clk);
    u_if.pix_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (u_if.lb0_we_o !== 1'b0 || busy !== 1'b0) begin
        n_errors++; $display("FAIL idle_pix: we=%b busy=%b want 0 0", u_if.lb0_we_o, busy);
      end
      @(posedge clk); #1;
      n_checks++;
      if (col !== 3'd7 || row !== 2'd3 || win_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL idle_hold: col=%0d row=%0d wv=%b want 7 3 0", col, row, win_valid);
      end
      @(negedge clk);
    end
    u_if.pix_valid_i = 1'b0;
    run_frame(40, -1, 1'b0, 1'b1, wv, dn);
    n_checks++;
    if (wv !== 12 || dn !== 1'b1) begin
      n_errors++; $display("FAIL noise_summary: wv=%0d done=%b want 12 1", wv, dn);
    end
  endtask

  initial begin
    u_if.pix_valid_i = 1'b0;
    test_reset();
    test_back_to_back();
    test_random_gaps();
    test_midframe_reset();
    test_err_row2();
    test_ignored_inputs();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_sobel_window_ctrl
`default_nettype wire
